// File: rtl/axi_write_arbiter_if.sv
// One AXI3 write port (AW, W, B channels). The master modport drives requests;
// the slave modport answers them.
interface axi_write_arbiter_if #(
   parameter int unsigned buswidth = 32
);
   logic [3:0]            awid;
   logic [31:0]           awaddr;
   logic [3:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic [1:0]            awlock;
   logic [3:0]            awcache;
   logic [2:0]            awprot;
   logic                  awvalid;
   logic                  awready;

   logic [3:0]            wid;
   logic [buswidth-1:0]   wdata;
   logic [buswidth/8-1:0] wstrb;
   logic                  wlast;
   logic                  wvalid;
   logic                  wready;

   logic [3:0]            bid;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/axi_write_arbiter.sv
// Round-robin arbiter letting two AXI3 write masters share one slave port,
// one complete AW/W/B transaction at a time.
module axi_write_arbiter #(
   parameter int unsigned buswidth = 32
) (
   input  logic                ACLK,
   input  logic                ARESETn,
   axi_write_arbiter_if.slave  m0,
   axi_write_arbiter_if.slave  m1,
   axi_write_arbiter_if.master s,
   output logic                grant,
   output logic                busy,
   output logic                len_err
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t                state;
   logic                  last_grant;
   logic [3:0]            beat_cnt;
   logic [3:0]            awlen_q;

   logic [3:0]            sel_awid;
   logic [31:0]           sel_awaddr;
   logic [3:0]            sel_awlen;
   logic [2:0]            sel_awsize;
   logic [1:0]            sel_awburst;
   logic [1:0]            sel_awlock;
   logic [3:0]            sel_awcache;
   logic [2:0]            sel_awprot;
   logic                  sel_awvalid;
   logic [3:0]            sel_wid;
   logic [buswidth-1:0]   sel_wdata;
   logic [buswidth/8-1:0] sel_wstrb;
   logic                  sel_wlast;
   logic                  sel_wvalid;
   logic                  sel_bready;
   logic                  aw_hs;
   logic                  w_hs;
   logic                  b_hs;

   assign sel_awid    = grant ? m1.awid    : m0.awid;
   assign sel_awaddr  = grant ? m1.awaddr  : m0.awaddr;
   assign sel_awlen   = grant ? m1.awlen   : m0.awlen;
   assign sel_awsize  = grant ? m1.awsize  : m0.awsize;
   assign sel_awburst = grant ? m1.awburst : m0.awburst;
   assign sel_awlock  = grant ? m1.awlock  : m0.awlock;
   assign sel_awcache = grant ? m1.awcache : m0.awcache;
   assign sel_awprot  = grant ? m1.awprot  : m0.awprot;
   assign sel_awvalid = grant ? m1.awvalid : m0.awvalid;
   assign sel_wid     = grant ? m1.wid     : m0.wid;
   assign sel_wdata   = grant ? m1.wdata   : m0.wdata;
   assign sel_wstrb   = grant ? m1.wstrb   : m0.wstrb;
   assign sel_wlast   = grant ? m1.wlast   : m0.wlast;
   assign sel_wvalid  = grant ? m1.wvalid  : m0.wvalid;
   assign sel_bready  = grant ? m1.bready  : m0.bready;

   assign aw_hs = (state == ADDR) && sel_awvalid && s.awready;
   assign w_hs  = (state == DATA) && sel_wvalid && s.wready;
   assign b_hs  = (state == RESP) && s.bvalid && sel_bready;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         busy       <= 1'b0;
         len_err    <= 1'b0;
         beat_cnt   <= '0;
         awlen_q    <= '0;
      end else begin
         len_err <= 1'b0;
         case (state)
            IDLE: begin
               if (m0.awvalid || m1.awvalid) begin
                  // On a tie the master not served last time wins.
                  if (m0.awvalid && m1.awvalid) grant <= ~last_grant;
                  else                          grant <= m1.awvalid;
                  state <= ADDR;
                  busy  <= 1'b1;
               end
            end
            ADDR: begin
               if (aw_hs) begin
                  awlen_q  <= sel_awlen;
                  beat_cnt <= '0;
                  state    <= DATA;
               end
            end
            DATA: begin
               if (w_hs) begin
                  if (beat_cnt != 4'hf) beat_cnt <= beat_cnt + 4'd1;
                  // beat_cnt still holds this beat's index; the last beat must be index awlen.
                  if (sel_wlast) begin
                     len_err <= (beat_cnt != awlen_q);
                     state   <= RESP;
                  end else if (beat_cnt == awlen_q) begin
                     len_err <= 1'b1;
                  end
               end
            end
            RESP: begin
               if (b_hs) begin
                  last_grant <= grant;
                  state      <= IDLE;
                  busy       <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      s.awid     = '0;
      s.awaddr   = '0;
      s.awlen    = '0;
      s.awsize   = '0;
      s.awburst  = '0;
      s.awlock   = '0;
      s.awcache  = '0;
      s.awprot   = '0;
      s.awvalid  = 1'b0;
      s.wid      = '0;
      s.wdata    = '0;
      s.wstrb    = '0;
      s.wlast    = 1'b0;
      s.wvalid   = 1'b0;
      s.bready   = 1'b0;
      m0.awready = 1'b0;
      m0.wready  = 1'b0;
      m0.bid     = '0;
      m0.bresp   = '0;
      m0.bvalid  = 1'b0;
      m1.awready = 1'b0;
      m1.wready  = 1'b0;
      m1.bid     = '0;
      m1.bresp   = '0;
      m1.bvalid  = 1'b0;
      case (state)
         ADDR: begin
            s.awid    = sel_awid;
            s.awaddr  = sel_awaddr;
            s.awlen   = sel_awlen;
            s.awsize  = sel_awsize;
            s.awburst = sel_awburst;
            s.awlock  = sel_awlock;
            s.awcache = sel_awcache;
            s.awprot  = sel_awprot;
            s.awvalid = sel_awvalid;
            if (grant) m1.awready = s.awready;
            else       m0.awready = s.awready;
         end
         DATA: begin
            s.wid    = sel_wid;
            s.wdata  = sel_wdata;
            s.wstrb  = sel_wstrb;
            s.wlast  = sel_wlast;
            s.wvalid = sel_wvalid;
            if (grant) m1.wready = s.wready;
            else       m0.wready = s.wready;
         end
         RESP: begin
            s.bready = sel_bready;
            if (grant) begin
               m1.bid    = s.bid;
               m1.bresp  = s.bresp;
               m1.bvalid = s.bvalid;
            end else begin
               m0.bid    = s.bid;
               m0.bresp  = s.bresp;
               m0.bvalid = s.bvalid;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Randomized bench for axi_write_arbiter: two master drivers and a slave model,
// with a transaction-level scoreboard checking routing, data order and len_err.
module tb_axi_write_arbiter;
   localparam int unsigned BW = 32;
   localparam int NT = 30;

   typedef struct packed {
      logic [3:0]        awid;
      logic [31:0]       addr;
      logic [3:0]        len;
      logic [2:0]        size;
      logic [1:0]        burst;
      logic [1:0]        lock;
      logic [3:0]        cache;
      logic [2:0]        prot;
      logic [3:0]        wid;
      logic [4:0]        nbeats;
      logic [15:0][31:0] data;
      logic [15:0][3:0]  strb;
   } txn_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   axi_write_arbiter_if #(.buswidth(BW)) m0_if ();
   axi_write_arbiter_if #(.buswidth(BW)) m1_if ();
   axi_write_arbiter_if #(.buswidth(BW)) s_if ();
   logic grant, busy, len_err;

   axi_write_arbiter #(.buswidth(BW)) dut (
      .ACLK(clk), .ARESETn(rst_n), .m0(m0_if), .m1(m1_if), .s(s_if),
      .grant(grant), .busy(busy), .len_err(len_err)
   );

   // Master-side stimulus state
   txn_t       cur [2];
   logic [3:0] bidx [2];
   logic [1:0] awv, wv, wl, br;
   // Master-side observed outputs
   logic [1:0] awr, wr, bv;
   logic [3:0] bid_o [2];
   logic [1:0] bresp_o [2];
   // Slave-side stimulus
   logic       s_awr, s_wr, s_bv;
   logic [3:0] s_bid;
   logic [1:0] s_bresp;

   assign m0_if.awid = cur[0].awid;   assign m1_if.awid = cur[1].awid;
   assign m0_if.awaddr = cur[0].addr; assign m1_if.awaddr = cur[1].addr;
   assign m0_if.awlen = cur[0].len;   assign m1_if.awlen = cur[1].len;
   assign m0_if.awsize = cur[0].size; assign m1_if.awsize = cur[1].size;
   assign m0_if.awburst = cur[0].burst; assign m1_if.awburst = cur[1].burst;
   assign m0_if.awlock = cur[0].lock; assign m1_if.awlock = cur[1].lock;
   assign m0_if.awcache = cur[0].cache; assign m1_if.awcache = cur[1].cache;
   assign m0_if.awprot = cur[0].prot; assign m1_if.awprot = cur[1].prot;
   assign m0_if.awvalid = awv[0];     assign m1_if.awvalid = awv[1];
   assign m0_if.wid = cur[0].wid;     assign m1_if.wid = cur[1].wid;
   assign m0_if.wdata = cur[0].data[bidx[0]]; assign m1_if.wdata = cur[1].data[bidx[1]];
   assign m0_if.wstrb = cur[0].strb[bidx[0]]; assign m1_if.wstrb = cur[1].strb[bidx[1]];
   assign m0_if.wlast = wl[0];        assign m1_if.wlast = wl[1];
   assign m0_if.wvalid = wv[0];       assign m1_if.wvalid = wv[1];
   assign m0_if.bready = br[0];       assign m1_if.bready = br[1];

   assign awr = {m1_if.awready, m0_if.awready};
   assign wr  = {m1_if.wready, m0_if.wready};
   assign bv  = {m1_if.bvalid, m0_if.bvalid};
   assign bid_o[0] = m0_if.bid;     assign bid_o[1] = m1_if.bid;
   assign bresp_o[0] = m0_if.bresp; assign bresp_o[1] = m1_if.bresp;

   assign s_if.awready = s_awr;
   assign s_if.wready  = s_wr;
   assign s_if.bvalid  = s_bv;
   assign s_if.bid     = s_bid;
   assign s_if.bresp   = s_bresp;

   int   checks = 0;
   int   errors = 0;
   int   done_txns = 0;
   txn_t q0 [$];
   txn_t q1 [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic txn_t make_txn(input logic [31:0] addr, input logic [3:0] len, input int nb);
      txn_t t;
      t = '0;
      t.awid   = 4'($urandom);
      t.addr   = addr;
      t.len    = len;
      t.size   = 3'd2;
      t.burst  = 2'd1;
      t.lock   = 2'($urandom_range(0, 1));
      t.cache  = 4'($urandom);
      t.prot   = 3'($urandom);
      t.wid    = t.awid;
      t.nbeats = 5'(nb);
      for (int i = 0; i < 16; i++) begin
         t.data[4'(i)] = $urandom;
         t.strb[4'(i)] = 4'($urandom);
      end
      return t;
   endfunction

   task automatic push_txn(input logic m, input txn_t t);
      if (m) q1.push_back(t);
      else   q0.push_back(t);
   endtask

   task automatic wait_aw(input logic m);
      logic h;
      do begin
         @(negedge clk); h = awv[m] && awr[m];
         @(posedge clk); #1;
      end while (!h);
   endtask

   task automatic wait_w(input logic m);
      logic h;
      do begin
         @(negedge clk); h = wv[m] && wr[m];
         @(posedge clk); #1;
      end while (!h);
   endtask

   task automatic wait_b(input logic m);
      logic h;
      do begin
         br[m] = ($urandom_range(0, 3) != 0);
         @(negedge clk); h = br[m] && bv[m];
         @(posedge clk); #1;
      end while (!h);
      br[m] = 1'b0;
   endtask

   task automatic run_txn(input logic m, input logic [31:0] addr, input logic [3:0] len,
                          input int nb, input int gap);
      txn_t t;
      repeat (gap) begin @(posedge clk); #1; end
      t = make_txn(addr, len, nb);
      push_txn(m, t);
      cur[m]  = t;
      bidx[m] = '0;
      wl[m]   = 1'b0;
      awv[m]  = 1'b1;
      fork
         begin
            wait_aw(m);
            awv[m] = 1'b0;
         end
         begin
            // W beats may be offered before AW completes; they must be held off.
            for (int b = 0; b < nb; b++) begin
               wv[m] = 1'b0;
               if ($urandom_range(0, 3) == 0)
                  repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
               bidx[m] = 4'(b);
               wl[m]   = (b == nb - 1);
               wv[m]   = 1'b1;
               wait_w(m);
            end
            wv[m] = 1'b0;
            wl[m] = 1'b0;
         end
      join
      wait_b(m);
   endtask

   task automatic rand_txns(input logic m);
      logic [31:0] addr;
      logic [3:0]  len;
      int          nb, gap;
      for (int i = 0; i < NT; i++) begin
         len  = 4'($urandom_range(0, 7));
         nb   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 10)) : int'(len) + 1;
         gap  = (i == 0 || $urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 4));
         addr = (i == 0) ? (m ? 32'h200 : 32'h100) : ($urandom & 32'hFFFF_FFFC);
         run_txn(m, addr, len, nb, gap);
      end
   endtask

   // Slave model: random back-pressure, one response per completed burst.
   initial begin
      int   stall;
      logic pend, hw, hb;
      stall = 0; pend = 1'b0;
      s_awr = 1'b0; s_wr = 1'b0; s_bv = 1'b0; s_bid = '0; s_bresp = '0;
      forever begin
         @(negedge clk);
         hw = s_if.wvalid && s_if.wready && s_if.wlast;
         hb = s_bv && s_if.bready;
         @(posedge clk); #1;
         if (!rst_n) begin
            pend = 1'b0; s_bv = 1'b0; stall = 0;
         end else begin
            if (hb) s_bv = 1'b0;
            if (hw) pend = 1'b1;
            if (pend && !s_bv) begin
               s_bv = 1'b1; s_bid = 4'($urandom); s_bresp = 2'($urandom); pend = 1'b0;
            end
         end
         s_awr = ($urandom_range(0, 2) != 0);
         if (stall > 0) begin
            stall--; s_wr = 1'b0;
         end else if ($urandom_range(0, 15) == 0) begin
            stall = 2; s_wr = 1'b0;
         end else begin
            s_wr = ($urandom_range(0, 3) != 0);
         end
      end
   end

   // Scoreboard: transaction-level arbitration model plus per-phase routing checks.
   logic in_txn, aw_done, w_done, last_m, exp_grant, lerr_exp, g, o, ewl;
   logic [3:0] bi;
   int   beat;
   txn_t t;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_txn = 0; aw_done = 0; w_done = 0; last_m = 1; exp_grant = 0;
            beat = 0; lerr_exp = 0;
            q0.delete(); q1.delete();
         end else begin
            check("len_err", 64'(len_err), 64'(lerr_exp));
            lerr_exp = 1'b0;
            check("grant", 64'(grant), 64'(exp_grant));
            check("busy", 64'(busy), 64'(in_txn));
            if (!in_txn) begin
               check("idle_quiet", 64'({s_if.awvalid, s_if.wvalid, s_if.bready, awr, wr, bv,
                                         (|s_if.awaddr), (|s_if.wdata)}), 64'd0);
               if (awv != 2'b00) begin
                  exp_grant = (awv == 2'b11) ? ~last_m : awv[1];
                  in_txn = 1; aw_done = 0; w_done = 0; beat = 0;
               end
            end else begin
               g = exp_grant;
               o = ~exp_grant;
               check("other_quiet", 64'({awr[o], wr[o], bv[o], bid_o[o], bresp_o[o]}), 64'd0);
               check("pending_txn", 64'(g ? q1.size() : q0.size()), 64'd1);
               if ((g ? q1.size() : q0.size()) > 0) begin
                  t = g ? q1[0] : q0[0];
                  if (!aw_done) begin
                     check("aw_route", 64'({s_if.awvalid, awr[g], s_if.wvalid, wr[g]}),
                           64'({awv[g], s_awr, 2'b00}));
                     if (awv[g] && s_awr) begin
                        check("aw_fields",
                              64'({s_if.awid, s_if.awaddr, s_if.awlen, s_if.awsize, s_if.awburst,
                                   s_if.awlock, s_if.awcache, s_if.awprot}),
                              64'({t.awid, t.addr, t.len, t.size, t.burst, t.lock, t.cache, t.prot}));
                        aw_done = 1;
                     end
                  end else if (!w_done) begin
                     check("w_route", 64'({s_if.wvalid, wr[g], s_if.awvalid, s_if.bready}),
                           64'({wv[g], s_wr, 2'b00}));
                     if (wv[g] && s_wr) begin
                        bi  = 4'(beat);
                        ewl = (beat == int'(t.nbeats) - 1);
                        check("w_beat", 64'({s_if.wid, s_if.wdata, s_if.wstrb, s_if.wlast}),
                              64'({t.wid, t.data[bi], t.strb[bi], ewl}));
                        lerr_exp = ewl ? (beat != int'(t.len)) : (beat == int'(t.len));
                        if (beat < 15) beat++;
                        if (ewl) w_done = 1;
                     end
                  end else begin
                     check("b_route", 64'({s_if.bready, bv[g], bid_o[g], bresp_o[g], s_if.wvalid, wr[g]}),
                           64'({br[g], s_bv, s_bid, s_bresp, 2'b00}));
                     if (s_bv && br[g]) begin
                        if (g) void'(q1.pop_front());
                        else   void'(q0.pop_front());
                        last_m = g;
                        in_txn = 0;
                        done_txns++;
                     end
                  end
               end
            end
         end
      end
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: actual=timeout required=completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      txn_t tr;
      rst_n = 1'b0;
      cur[0] = '0; cur[1] = '0; bidx[0] = '0; bidx[1] = '0;
      awv = '0; wv = '0; wl = '0; br = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 64'({busy, grant, len_err, s_if.awvalid, s_if.wvalid, s_if.bready,
                                awr, wr, bv}), 64'd0);
      rst_n = 1'b1;

      fork
         rand_txns(1'b0);
         rand_txns(1'b1);
      join

      // Abort a burst with reset after two of four beats.
      repeat (2) begin @(posedge clk); #1; end
      tr = make_txn(32'h300, 4'd3, 4);
      push_txn(1'b0, tr);
      cur[0] = tr; bidx[0] = '0; wl[0] = 1'b0; awv[0] = 1'b1;
      wait_aw(1'b0);
      awv[0] = 1'b0;
      for (int b = 0; b < 2; b++) begin
         bidx[0] = 4'(b); wv[0] = 1'b1;
         wait_w(1'b0);
      end
      bidx[0] = 4'd2;
      #1;
      rst_n = 1'b0;
      #1;
      check("reset_async", 64'({busy, grant, len_err, s_if.awvalid, s_if.wvalid, s_if.bready,
                                awr, wr, bv, (|s_if.wdata)}), 64'd0);
      wv[0] = 1'b0; wl[0] = 1'b0; awv = '0; br = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_txn(1'b1, 32'h400, 4'd1, 2, 0);
      fork
         run_txn(1'b0, 32'h500, 4'd2, 3, 0);
         run_txn(1'b1, 32'h600, 4'd0, 1, 0);
      join

      repeat (3) @(posedge clk);
      #1;
      check("txn_count", 64'(done_txns), 64'(2 * NT + 3));
      check("queues_empty", 64'(q0.size() + q1.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
